// File: rtl/adc_uart_framer.sv
// Purpose : decimates ADC ch1/ch2 sample pairs and frames each captured pair into a 7-byte UART packet.
// Latency : SYNC byte valid on the cycle after the capture edge; one byte per accepted handshake.
// Backpr. : bytes hold on o_tx_data until i_tx_ready; capture points arriving mid-frame are dropped and flag o_overrun.
//
// Ports:
//   i_clock, i_reset_n          clock, async active-low reset
//   i_enable, i_decim           run enable, capture every (i_decim+1)-th valid sample
//   i_sample_valid, i_ch1/ch2   incoming sample pair
//   o_tx_data/valid, i_tx_ready AXI-stream byte output towards uart_tx
//   i_clear_overrun, o_overrun  sticky lost-sample flag and its clear
//   o_busy                      high while a frame is being sent
module adc_uart_framer #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         DECIM_WIDTH = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_enable,
    input  logic [DECIM_WIDTH-1:0] i_decim,
    input  logic                   i_sample_valid,
    input  logic [15:0]            i_ch1,
    input  logic [15:0]            i_ch2,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    input  logic                   i_clear_overrun,
    output logic                   o_overrun,
    output logic                   o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_idx;
    logic [7:0]             r_seq;
    logic [15:0]            r_ch1;
    logic [15:0]            r_ch2;
    logic [DECIM_WIDTH-1:0] r_dcnt;

    logic                   w_capture;
    logic                   w_accept;
    logic                   w_last;
    logic [7:0]             w_chk;
    logic [2:0]             w_next_idx;
    logic [7:0]             w_next_byte;

    assign w_capture  = i_enable && i_sample_valid && (r_dcnt == i_decim);
    assign w_accept   = (r_state == S_SEND) && o_tx_valid && i_tx_ready;
    assign w_last     = w_accept && (r_idx == 3'd6);
    assign w_chk      = r_seq ^ r_ch1[15:8] ^ r_ch1[7:0] ^ r_ch2[15:8] ^ r_ch2[7:0];
    assign w_next_idx = r_idx + 3'd1;

    // Byte that goes out after the current one is accepted.
    always_comb begin
        w_next_byte = 8'h00;
        case (w_next_idx)
            3'd0:    w_next_byte = SYNC_BYTE;
            3'd1:    w_next_byte = r_seq;
            3'd2:    w_next_byte = r_ch1[15:8];
            3'd3:    w_next_byte = r_ch1[7:0];
            3'd4:    w_next_byte = r_ch2[15:8];
            3'd5:    w_next_byte = r_ch2[7:0];
            3'd6:    w_next_byte = w_chk;
            default: w_next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 3'd0;
            r_seq      <= 8'h00;
            r_ch1      <= 16'h0000;
            r_ch2      <= 16'h0000;
            r_dcnt     <= '0;
            o_tx_data  <= 8'h00;
            o_tx_valid <= 1'b0;
            o_overrun  <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            if (!i_enable) begin
                r_dcnt <= '0;
            end else if (i_sample_valid) begin
                r_dcnt <= (r_dcnt == i_decim) ? '0 : r_dcnt + DECIM_WIDTH'(1);
            end

            // A capture coinciding with the final handshake is a legal back-to-back start.
            if (w_capture && (r_state == S_SEND) && !w_last) begin
                o_overrun <= 1'b1;
            end else if (i_clear_overrun) begin
                o_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_capture) begin
                        r_ch1      <= i_ch1;
                        r_ch2      <= i_ch2;
                        r_idx      <= 3'd0;
                        o_tx_data  <= SYNC_BYTE;
                        o_tx_valid <= 1'b1;
                        o_busy     <= 1'b1;
                        r_state    <= S_SEND;
                    end else if (!i_enable) begin
                        r_state <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (w_accept) begin
                        if (r_idx == 3'd6) begin
                            r_seq <= r_seq + 8'd1;
                            if (w_capture) begin
                                r_ch1     <= i_ch1;
                                r_ch2     <= i_ch2;
                                r_idx     <= 3'd0;
                                o_tx_data <= SYNC_BYTE;
                            end else begin
                                o_tx_valid <= 1'b0;
                                o_busy     <= 1'b0;
                                r_state    <= i_enable ? S_WAIT : S_IDLE;
                            end
                        end else begin
                            r_idx     <= w_next_idx;
                            o_tx_data <= w_next_byte;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_uart_framer.sv
module tb_adc_uart_framer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] decim;
    logic        sample_valid;
    logic [15:0] ch1;
    logic [15:0] ch2;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        clear_ovr;
    logic        overrun;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    adc_uart_framer #(.SYNC_BYTE(8'hA5), .DECIM_WIDTH(16)) dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_enable        (enable),
        .i_decim         (decim),
        .i_sample_valid  (sample_valid),
        .i_ch1           (ch1),
        .i_ch2           (ch2),
        .o_tx_data       (tx_data),
        .o_tx_valid      (tx_valid),
        .i_tx_ready      (tx_ready),
        .i_clear_overrun (clear_ovr),
        .o_overrun       (overrun),
        .o_busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: byte 0 in the top byte.
    function automatic logic [55:0] mk_frame(input logic [7:0] seq, input logic [15:0] c1, input logic [15:0] c2);
        logic [7:0] x;
        x = seq ^ c1[15:8] ^ c1[7:0] ^ c2[15:8] ^ c2[7:0];
        return {8'hA5, seq, c1[15:8], c1[7:0], c2[15:8], c2[7:0], x};
    endfunction

    // All tasks start and end at a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        clear_ovr    = 1'b0;
        tx_ready     = 1'b1;
        ch1          = 16'h0000;
        ch2          = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start(input logic [15:0] d);
        decim  = d;
        enable = 1'b1;
        idle(2);
    endtask

    task automatic send_sample(input logic [15:0] c1, input logic [15:0] c2);
        sample_valid = 1'b1;
        ch1          = c1;
        ch2          = c2;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Collect one 7-byte frame. tog toggles tx_ready; inj injects a sample at that
    // iteration; dis drops i_enable at that iteration. Iteration k sees byte k when ready=1.
    task automatic get_frame(input bit tog, input int inj, input logic [15:0] ic1, input logic [15:0] ic2,
                             input int dis, output logic [55:0] f, output int cyc);
        int         n       = 0;
        bit         rdy     = 1'b0;
        bit         holding = 1'b0;
        logic [7:0] held    = 8'h00;
        f   = '0;
        cyc = 0;
        while (n < 7 && cyc < 100) begin
            if (holding) begin
                chk("hold_valid", 64'(tx_valid), 64'd1);
                chk("hold_data", 64'(tx_data), 64'(held));
            end
            rdy      = tog ? ~rdy : 1'b1;
            tx_ready = rdy;
            sample_valid = (cyc == inj);
            if (cyc == inj) begin
                ch1 = ic1;
                ch2 = ic2;
            end
            if (cyc == dis) enable = 1'b0;
            if (tx_valid) begin
                if (rdy) begin
                    f       = {f[47:0], tx_data};
                    n++;
                    holding = 1'b0;
                end else begin
                    held    = tx_data;
                    holding = 1'b1;
                end
            end
            cyc++;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        tx_ready     = 1'b1;
        chk("frame_len", 64'(n), 64'd7);
    endtask

    initial begin
        logic [55:0] f;
        int          cyc;
        int          frames;
        logic [15:0] c1;
        logic [15:0] c2;
        logic [7:0]  seq;

        decim = 16'd0;
        do_reset();

        // Reset state
        chk("rst_valid", 64'(tx_valid), 64'd0);
        chk("rst_data", 64'(tx_data), 64'h00);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);

        // Basic frame
        start(16'd0);
        send_sample(16'h1234, 16'hABCD);
        chk("basic_busy_on", 64'(busy), 64'd1);
        get_frame(1'b0, -1, 16'h0, 16'h0, -1, f, cyc);
        chk("basic_frame", 64'(f), 64'h00A5_0012_34AB_CD40);
        chk("basic_cycles", 64'(cyc), 64'd7);
        chk("basic_busy_off", 64'(busy), 64'd0);
        chk("basic_valid_off", 64'(tx_valid), 64'd0);

        // Backpressure
        do_reset();
        start(16'd0);
        send_sample(16'h1234, 16'hABCD);
        get_frame(1'b1, -1, 16'h0, 16'h0, -1, f, cyc);
        chk("bp_frame", 64'(f), 64'h00A5_0012_34AB_CD40);

        // Decimation: every 4th sample captured
        do_reset();
        start(16'd3);
        frames = 0;
        for (int k = 1; k <= 8; k++) begin
            c1 = 16'(256 + k);
            c2 = 16'(16'hF000 + k);
            send_sample(c1, c2);
            if (k % 4 == 0) begin
                get_frame(1'b0, -1, 16'h0, 16'h0, -1, f, cyc);
                chk("decim_frame", 64'(f), 64'(mk_frame(8'(frames), c1, c2)));
                frames++;
                idle(19 - cyc);
            end else begin
                chk("decim_no_frame", 64'(tx_valid), 64'd0);
                idle(19);
            end
        end
        chk("decim_count", 64'(frames), 64'd2);

        // Overrun: second sample 3 cycles after the first is dropped
        do_reset();
        start(16'd0);
        send_sample(16'hDEAD, 16'hBEEF);
        get_frame(1'b0, 2, 16'h5555, 16'h6666, -1, f, cyc);
        chk("ovr_frame_intact", 64'(f), 64'(mk_frame(8'h00, 16'hDEAD, 16'hBEEF)));
        chk("ovr_set", 64'(overrun), 64'd1);
        idle(2);
        chk("ovr_dropped", 64'(tx_valid), 64'd0);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        clear_ovr = 1'b1;
        @(negedge clk);
        clear_ovr = 1'b0;
        chk("ovr_cleared", 64'(overrun), 64'd0);

        // Capture on the byte-6 handshake: back-to-back, no overrun
        send_sample(16'h1111, 16'h2222);
        get_frame(1'b0, 6, 16'h3333, 16'h4444, -1, f, cyc);
        chk("b2b_first", 64'(f), 64'(mk_frame(8'h01, 16'h1111, 16'h2222)));
        chk("b2b_no_gap", 64'(tx_valid), 64'd1);
        chk("b2b_sync", 64'(tx_data), 64'hA5);
        get_frame(1'b0, -1, 16'h0, 16'h0, -1, f, cyc);
        chk("b2b_second", 64'(f), 64'(mk_frame(8'h02, 16'h3333, 16'h4444)));
        chk("b2b_cycles", 64'(cyc), 64'd7);
        chk("b2b_no_overrun", 64'(overrun), 64'd0);

        // SEQ wrap over 257 frames
        do_reset();
        start(16'd0);
        for (int k = 1; k <= 257; k++) begin
            c1  = 16'(k * 291);
            c2  = 16'(k * 7919);
            seq = 8'(k - 1);
            send_sample(c1, c2);
            get_frame(1'b0, -1, 16'h0, 16'h0, -1, f, cyc);
            chk("wrap_frame", 64'(f), 64'(mk_frame(seq, c1, c2)));
            if (k == 256) chk("wrap_seq_ff", 64'(f[47:40]), 64'hFF);
            if (k == 257) chk("wrap_seq_00", 64'(f[47:40]), 64'h00);
            idle(1);
        end

        // Enable dropped at byte 2: frame completes, then silence
        send_sample(16'hCAFE, 16'hF00D);
        get_frame(1'b0, -1, 16'h0, 16'h0, 2, f, cyc);
        chk("dis_frame", 64'(f), 64'(mk_frame(8'h01, 16'hCAFE, 16'hF00D)));
        chk("dis_busy", 64'(busy), 64'd0);
        send_sample(16'h0001, 16'h0002);
        for (int k = 0; k < 20; k++) begin
            chk("dis_silent", 64'(tx_valid), 64'd0);
            @(negedge clk);
        end

        // Async reset at byte 4
        do_reset();
        start(16'd0);
        send_sample(16'h8001, 16'h7FFE);
        idle(4);
        chk("arst_pre_valid", 64'(tx_valid), 64'd1);
        chk("arst_pre_byte4", 64'(tx_data), 64'h7F);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(tx_valid), 64'd0);
        chk("arst_data", 64'(tx_data), 64'h00);
        chk("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        do_reset();
        start(16'd0);
        send_sample(16'h0F0F, 16'hF0F0);
        chk("arst_restart_sync", 64'(tx_data), 64'hA5);
        get_frame(1'b0, -1, 16'h0, 16'h0, -1, f, cyc);
        chk("arst_restart_frame", 64'(f), 64'(mk_frame(8'h00, 16'h0F0F, 16'hF0F0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
